fir_output_requantizer: RTL and testbench
=========================================

// Module: fir_output_requantizer
// PURPOSE
//  Downstream stage of the direct-form FIR filter. Takes the filter's full-precision accumulator output
//  and requantizes it: round-half-up arithmetic right shift by SHIFT, then saturate to OUT_WIDTH signed.
//  The requantized samples are buffered in a DEPTH-entry FIFO behind a valid/ready interface.
//  Saturation events and dropped samples are counted for debug visibility.
// PARAMETERS
//  WIDTH      32  width of incoming FIR output sample (signed two's complement)
//  OUT_WIDTH  16  width of requantized output sample (signed); OUT_WIDTH <= WIDTH
//  SHIFT      15  coefficient scale exponent k; samples are divided by 2^k with rounding; 0 = no shift
//  DEPTH      8   FIFO entries; power of two, >= 2
//  CNT_WIDTH  16  width of sat_count and drop_count
// PORTS
//  clk         in   1          single clock, all logic on posedge
//  reset       in   1          synchronous, active-high
//  in_sample   in   WIDTH      FIR output y, signed
//  in_valid    in   1          in_sample valid this cycle (no backpressure; FIR never stalls)
//  out_sample  out  OUT_WIDTH  requantized sample at FIFO head, signed
//  out_valid   out  1          FIFO non-empty
//  out_ready   in   1          consumer accepts; pop when out_valid && out_ready
//  fifo_count  out  log2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
//  sat_count   out  CNT_WIDTH  number of saturated samples, saturating counter
//  drop_count  out  CNT_WIDTH  number of samples dropped on full FIFO, saturating counter
//  overflow    out  1          sticky: set on first drop, cleared only by reset
// BEHAVIOUR
//  Reset: on posedge clk with reset=1, all outputs go to 0, FIFO is emptied, pointers are cleared, and the
//   stage-1 valid bit is cleared. Reset overrides any simultaneous push or pop. Any sample in flight is discarded.
//  Stage 1 (registered, every cycle in_valid=1):
//   t = sign_ext(in_sample, WIDTH+1) + (SHIFT>0 ? 2^(SHIFT-1) : 0).
//   Compute t in WIDTH+1 bits so the rounding add cannot wrap.
//   r = t >>> SHIFT (arithmetic).
//   If r > 2^(OUT_WIDTH-1)-1, the result is that maximum; if r < -2^(OUT_WIDTH-1), the result is that minimum.
//   Any clamp sets s1_sat for that sample.
//   s1_valid <= in_valid. Stage 1 never stalls.
//  Stage 2 (FIFO push): if s1_valid, push the stage-1 result.
//   If the FIFO is full and no pop occurs in the same cycle, the sample is dropped:
//   drop_count increments (holds at all-ones) and overflow is set to 1.
//   If the FIFO is full and a pop occurs in the same cycle, the push succeeds and the count stays DEPTH.
//  sat_count increments only for samples that are actually written into the FIFO (not for dropped samples).
//   It holds at all-ones.
//  Latency: sample presented at edge N is written at edge N+1; out_valid/out_sample are visible after N+1.
//   Minimum latency is therefore 2 cycles.
//  Pop: occurs when out_valid && out_ready. out_sample always shows the head entry (registered RAM read or
//   head register); when FIFO is empty, out_sample is don't-care and holds its last value.
//  Simultaneous push and pop:
//   - count is unchanged;
//   - if empty, no pop occurs (out_valid=0), and the push makes count=1.
//  Pointers: read and write pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0. Full/empty are derived
//   from fifo_count.
//  out_ready is ignored when out_valid=0. in_valid=0 produces no push and no counter change.
// TESTING (defaults unless noted)
//  1. Rounding: in_sample = 16384, 16383, -16384, -16385 back to back; out_ready=1.
//     Expected out = 1, 0, 0, -1 in order, 2 cycles after each input; sat_count=0.
//  2. Saturation: in_sample = 32'h4000_0000, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000.
//     Expected out = 32767, 32767, -32768, -32768; sat_count=3; 32'h7FFF_FFFF must not wrap negative.
//  3. Overflow: out_ready=0; send 10 valid samples 1..10 (<<15).
//     Expected fifo_count=8, drop_count=2, overflow=1. Then out_ready=1: pops 1..8 in order, then out_valid=0.
//  4. Full + push + pop: fill to 8, then in the same cycle push 99<<15 with out_ready=1.
//     Expected count stays 8, drop_count unchanged, and 99 appears last after draining.
//  5. Reset mid-operation: FIFO holds 5 and overflow=1; assert reset for 1 cycle alongside in_valid.
//     Expected all outputs 0, out_valid=0, and the in-flight sample is not written.
//  6. Wrap-around: out_ready=1 continuously, 100 ramp samples k<<15.
//     Expected outputs 0..99 in order, count never exceeds 1, no drops; also run SHIFT=0, OUT_WIDTH=WIDTH
//     as a pass-through check.

Source files
------------

// File: rtl/fir_output_requantizer.sv
// fir_output_requantizer
//   Requantizes the full-precision output of the direct-form FIR filter and
//   buffers it for a downstream consumer.
//   Each valid input is rounded (round-half-up) while being divided by
//   2^SHIFT with an arithmetic shift. The result is then saturated to
//   OUT_WIDTH signed bits and pushed into a DEPTH-entry FIFO that is read
//   through a valid/ready port. Saturated writes and drops caused by a full
//   FIFO are counted for debug.
//
// Ports
//   clk         clock, all logic on posedge
//   reset       synchronous, active-high
//   in_sample   FIR output sample, signed WIDTH bits
//   in_valid    in_sample valid this cycle (the FIR never stalls)
//   out_sample  requantized sample at the FIFO head, signed OUT_WIDTH bits
//   out_valid   FIFO non-empty
//   out_ready   consumer accepts the head entry
//   fifo_count  FIFO occupancy, 0..DEPTH
//   sat_count   saturated samples written to the FIFO (saturating counter)
//   drop_count  samples lost on a full FIFO (saturating counter)
//   overflow    sticky flag, set by the first drop
module fir_output_requantizer #(
  parameter int WIDTH     = 32,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 15,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic signed [WIDTH-1:0]       in_sample,
  input  logic                          in_valid,
  output logic signed [OUT_WIDTH-1:0]   out_sample,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DEPTH):0]        fifo_count,
  output logic [CNT_WIDTH-1:0]          sat_count,
  output logic [CNT_WIDTH-1:0]          drop_count,
  output logic                          overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Half an output LSB, added before the shift to round half up.
  localparam logic signed [WIDTH:0] RND =
    (SHIFT > 0) ? ((WIDTH+1)'(1) <<< ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;

  // OUT_WIDTH signed limits, expressed in the WIDTH+1 bit working precision.
  localparam logic signed [WIDTH:0] SAT_MAX =
    {{(WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
  localparam logic signed [WIDTH:0] SAT_MIN =
    {{(WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

  // One extra bit of headroom, so adding RND to the most positive input
  // cannot wrap negative.
  function automatic logic signed [WIDTH:0] round_shift(
    input logic signed [WIDTH-1:0] x
  );
    logic signed [WIDTH:0] t;
    t = {x[WIDTH-1], x};
    t = t + RND;
    return t >>> SHIFT;
  endfunction

  // Returns {clamped, value}.
  function automatic logic [OUT_WIDTH:0] saturate(
    input logic signed [WIDTH:0] r
  );
    if (r > SAT_MAX) begin
      return {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    end else if (r < SAT_MIN) begin
      return {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    end else begin
      return {1'b0, r[OUT_WIDTH-1:0]};
    end
  endfunction

  // ---------------- stage 1: round, shift, saturate ----------------
  logic signed [OUT_WIDTH-1:0] data_p1;
  logic                        sat_p1;
  logic                        vld_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      {sat_p1, data_p1} <= saturate(round_shift(in_sample));
    end
  end

  // ---------------- stage 2: FIFO push / pop ----------------
  logic signed [OUT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [AW-1:0]               rd_ptr_nxt;
  logic [CW-1:0]               count_nxt;
  logic                        full;
  logic                        pop;
  logic                        push;
  logic                        drop;

  assign out_valid = (fifo_count != '0);
  assign full      = (fifo_count == CW'(DEPTH));
  assign pop       = out_valid && out_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push      = vld_p1 && (!full || pop);
  assign drop      = vld_p1 && full && !pop;

  always_comb begin
    rd_ptr_nxt = rd_ptr;
    count_nxt  = fifo_count;
    if (pop) begin
      rd_ptr_nxt = rd_ptr + AW'(1);
    end
    if (push && !pop) begin
      count_nxt = fifo_count + CW'(1);
    end else if (pop && !push) begin
      count_nxt = fifo_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      sat_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      out_sample <= '0;
    end else begin
      rd_ptr     <= rd_ptr_nxt;
      fifo_count <= count_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (push && sat_p1 && (sat_count != '1)) begin
        sat_count <= sat_count + CNT_WIDTH'(1);
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) begin
          drop_count <= drop_count + CNT_WIDTH'(1);
        end
      end
      // Head register holds the entry that will sit at the head after this
      // edge. When the write lands exactly on the new head slot, the RAM
      // still holds stale data, so the incoming sample is forwarded instead.
      // When the FIFO goes empty, the last value is kept.
      if (count_nxt != '0) begin
        if (push && (wr_ptr == rd_ptr_nxt)) begin
          out_sample <= data_p1;
        end else begin
          out_sample <= mem[rd_ptr_nxt];
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_output_requantizer.sv
module tb_fir_output_requantizer;
  localparam int W  = 32;
  localparam int OW = 16;
  localparam int SH = 15;
  localparam int D  = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic signed [W-1:0]  in_sample;
  logic                 in_valid;
  logic signed [OW-1:0] out_sample;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           fifo_count;
  logic [CW-1:0]        sat_count;
  logic [CW-1:0]        drop_count;
  logic                 overflow;

  // Pass-through instance: SHIFT=0, OUT_WIDTH=WIDTH
  logic signed [W-1:0]  pt_sample;
  logic                 pt_valid;
  logic                 pt_ready = 1'b1;
  logic [3:0]           pt_count;
  logic [CW-1:0]        pt_sat;
  logic [CW-1:0]        pt_drop;
  logic                 pt_ovf;

  fir_output_requantizer #(.WIDTH(W), .OUT_WIDTH(OW), .SHIFT(SH), .DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
    .out_sample(out_sample), .out_valid(out_valid), .out_ready(out_ready),
    .fifo_count(fifo_count), .sat_count(sat_count), .drop_count(drop_count),
    .overflow(overflow));

  fir_output_requantizer #(.WIDTH(W), .OUT_WIDTH(W), .SHIFT(0), .DEPTH(D), .CNT_WIDTH(CW)) dut_pt (
    .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
    .out_sample(pt_sample), .out_valid(pt_valid), .out_ready(pt_ready),
    .fifo_count(pt_count), .sat_count(pt_sat), .drop_count(pt_drop),
    .overflow(pt_ovf));

  int checks = 0;
  int errors = 0;
  logic signed [OW-1:0] sbq[$];
  logic signed [OW-1:0] mon_exp;

  // Reference requantizer: floor((x + 2^(sh-1)) / 2^sh), then clamp.
  function automatic longint model(longint x, int sh, int ow);
    longint t, r, mx, mn;
    t  = x + ((sh > 0) ? (longint'(1) <<< (sh - 1)) : longint'(0));
    r  = t >>> sh;
    mx = (longint'(1) <<< (ow - 1)) - 1;
    mn = -(longint'(1) <<< (ow - 1));
    if (r > mx) r = mx;
    if (r < mn) r = mn;
    return r;
  endfunction

  // Scoreboard: each pop seen by the DUT is compared with the queue head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: got out_sample=%0d, required no output", out_sample);
      end else begin
        mon_exp = sbq.pop_front();
        if (out_sample !== mon_exp) begin
          errors++;
          $display("FAIL pop_data: got %0d, required %0d", out_sample, mon_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [W-1:0] v);
    in_sample = v;
    in_valid  = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    sbq.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (sbq.size() != 0 || out_valid); i++) tick();
  endtask

  task automatic test_reset();
    checks++;
    if (fifo_count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_fifo: got count=%0d valid=%b, required 0/0", fifo_count, out_valid);
    end
    checks++;
    if (sat_count !== 16'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_counters: got sat=%0d drop=%0d ovf=%b, required 0/0/0",
               sat_count, drop_count, overflow);
    end
    checks++;
    if (out_sample !== 16'sd0) begin
      errors++;
      $display("FAIL reset_out_sample: got %0d, required 0", out_sample);
    end
  endtask

  task automatic test_rounding();
    logic signed [W-1:0] vals [4];
    vals[0] = 16384; vals[1] = 16383; vals[2] = -16384; vals[3] = -16385;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sbq.push_back(OW'(model(longint'(vals[i]), SH, OW)));
      send(vals[i]);
      if (i == 0) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL latency_early: got out_valid=%b one edge after input, required 0", out_valid);
        end
      end
      if (i == 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_sample !== 16'sd1) begin
          errors++;
          $display("FAIL latency_2cyc: got valid=%b sample=%0d, required 1/1", out_valid, out_sample);
        end
      end
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (sbq.size() != 0 || sat_count !== 16'd0) begin
      errors++;
      $display("FAIL rounding_done: got pending=%0d sat=%0d, required 0/0", sbq.size(), sat_count);
    end
  endtask

  task automatic test_saturation();
    logic signed [W-1:0]  vals [4];
    logic signed [OW-1:0] exps [4];
    vals[0] = 32'sh4000_0000; exps[0] = 16'sd32767;
    vals[1] = 32'sh7FFF_FFFF; exps[1] = 16'sd32767;
    vals[2] = 32'sh8000_0000; exps[2] = -16'sd32768;
    vals[3] = 32'shC000_0000; exps[3] = -16'sd32768;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sbq.push_back(exps[i]);
      send(vals[i]);
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (sbq.size() != 0 || sat_count !== 16'd3) begin
      errors++;
      $display("FAIL saturation_count: got pending=%0d sat=%0d, required 0/3", sbq.size(), sat_count);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 8) sbq.push_back(OW'(k));
      send(32'(k) << 15);
    end
    in_valid = 1'b0;
    tick();
    tick();
    checks++;
    if (fifo_count !== 4'd8 || drop_count !== 16'd2 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_state: got count=%0d drop=%0d ovf=%b, required 8/2/1",
               fifo_count, drop_count, overflow);
    end
    out_ready = 1'b1;
    drain();
    checks++;
    if (sbq.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overflow_drain: got pending=%0d valid=%b, required 0/0", sbq.size(), out_valid);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    out_ready = 1'b0;
    for (int k = 11; k <= 18; k++) begin
      sbq.push_back(OW'(k));
      send(32'(k) << 15);
    end
    sbq.push_back(16'sd99);
    send(32'(99) << 15);
    in_valid = 1'b0;
    checks++;
    if (fifo_count !== 4'd8) begin
      errors++;
      $display("FAIL full_before: got count=%0d, required 8", fifo_count);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (fifo_count !== 4'd8 || drop_count !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_push_pop: got count=%0d drop=%0d ovf=%b, required 8/0/0",
               fifo_count, drop_count, overflow);
    end
    out_ready = 1'b1;
    drain();
    checks++;
    if (sbq.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_drain: got pending=%0d valid=%b, required 0/0", sbq.size(), out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 8) sbq.push_back(OW'(k));
      send(32'(k) << 15);
    end
    in_valid = 1'b0;
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    out_ready = 1'b0;
    checks++;
    if (fifo_count !== 4'd5 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL midreset_pre: got count=%0d ovf=%b, required 5/1", fifo_count, overflow);
    end
    reset     = 1'b1;
    in_valid  = 1'b1;
    in_sample = 32'(77) << 15;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
    checks++;
    if (fifo_count !== 4'd0 || out_valid !== 1'b0 || out_sample !== 16'sd0) begin
      errors++;
      $display("FAIL midreset_fifo: got count=%0d valid=%b sample=%0d, required 0/0/0",
               fifo_count, out_valid, out_sample);
    end
    checks++;
    if (sat_count !== 16'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL midreset_counters: got sat=%0d drop=%0d ovf=%b, required 0/0/0",
               sat_count, drop_count, overflow);
    end
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (fifo_count !== 4'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_inflight: got count=%0d valid=%b, required 0/0", fifo_count, out_valid);
    end
  endtask

  task automatic test_wraparound();
    int maxc;
    maxc = 0;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      sbq.push_back(OW'(k));
      send(32'(k) << 15);
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (sbq.size() != 0 || maxc > 1 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL wraparound: got pending=%0d maxcount=%0d drop=%0d, required 0/<=1/0",
               sbq.size(), maxc, drop_count);
    end
  endtask

  task automatic test_passthrough();
    logic signed [W-1:0] vals [5];
    vals[0] = 32'sh7FFF_FFFF; vals[1] = 32'sh8000_0000; vals[2] = -32'sd1;
    vals[3] = 32'sd12345;     vals[4] = 32'sd1;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sbq.push_back(OW'(model(longint'(vals[i]), SH, OW)));
      send(vals[i]);
      in_valid = 1'b0;
      tick();
      checks++;
      if (pt_valid !== 1'b1 || pt_sample !== vals[i]) begin
        errors++;
        $display("FAIL passthrough_%0d: got valid=%b sample=%0d, required 1/%0d",
                 i, pt_valid, pt_sample, vals[i]);
      end
    end
    drain();
    checks++;
    if (sbq.size() != 0 || pt_sat !== 16'd0) begin
      errors++;
      $display("FAIL passthrough_done: got pending=%0d pt_sat=%0d, required 0/0", sbq.size(), pt_sat);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sample = '0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_rounding();
    test_saturation();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    test_wraparound();
    test_passthrough();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
